// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned PORT_CORE = 0;
   localparam int unsigned PORT_DMA  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the port that wins a tie.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   input  logic       i_enable,
   output logic [1:0] o_grant,
   output logic       o_winner
);

   always_comb begin
      o_grant  = 2'b00;
      o_winner = 1'b0;
      if (i_enable) begin
         case (i_req)
            2'b01: begin
               o_grant[PORT_CORE] = 1'b1;
               o_winner           = 1'(PORT_CORE);
            end
            2'b10: begin
               o_grant[PORT_DMA] = 1'b1;
               o_winner          = 1'(PORT_DMA);
            end
            2'b11: begin
               o_winner         = i_ptr;
               o_grant[i_ptr]   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core (port 0) and the
// debug/DMA loader (port 1); one registered transaction every two cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [1:0]            i_req_valid,
   output logic [1:0]            o_req_ready,
   input  logic [1:0]            i_req_we,
   input  logic [2*ADDR_W-1:0]   i_req_addr,
   input  logic [2*DATA_W-1:0]   i_req_wdata,
   input  logic [5:0]            i_req_funct3,
   output logic [1:0]            o_rsp_valid,
   output logic [DATA_W-1:0]     o_rsp_rdata,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic [ADDR_W-1:0]     o_mem_a,
   output logic [DATA_W-1:0]     o_mem_wd,
   output logic [2:0]            o_mem_funct3,
   input  logic [DATA_W-1:0]     i_mem_rd
);

   state_e              r_state;
   state_e              w_state_next;
   logic                r_rr_ptr;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [2:0]          r_funct3;
   logic                r_owner;
   logic [DATA_W-1:0]   r_rsp_rdata;

   logic                w_accept_en;
   logic                w_accept;
   logic [1:0]          w_grant;
   logic                w_winner;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic [2:0]          w_sel_funct3;

   rr_arb2 u_arb (
      .i_req    (i_req_valid),
      .i_ptr    (r_rr_ptr),
      .i_enable (w_accept_en),
      .o_grant  (w_grant),
      .o_winner (w_winner)
   );

   always_comb begin
      w_accept_en = (r_state == IDLE) || (r_state == RESP);
      w_accept    = |w_grant;
      // With nothing pending both ports see ready; otherwise only the winner.
      if (!w_accept_en) begin
         o_req_ready = 2'b00;
      end else if (i_req_valid == 2'b00) begin
         o_req_ready = 2'b11;
      end else begin
         o_req_ready = w_grant;
      end
   end

   always_comb begin
      w_sel_we     = i_req_we[w_winner];
      w_sel_addr   = w_winner ? i_req_addr[ADDR_W +: ADDR_W]   : i_req_addr[0 +: ADDR_W];
      w_sel_wdata  = w_winner ? i_req_wdata[DATA_W +: DATA_W] : i_req_wdata[0 +: DATA_W];
      w_sel_funct3 = w_winner ? i_req_funct3[5:3]             : i_req_funct3[2:0];
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = ISSUE;
         ISSUE:   w_state_next = RESP;
         RESP:    w_state_next = w_accept ? ISSUE : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rr_ptr    <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_funct3    <= 3'b000;
         r_owner     <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_funct3 <= w_sel_funct3;
            r_owner  <= w_winner;
            r_rr_ptr <= ~w_winner;
         end
         if (r_state == ISSUE) begin
            r_rsp_rdata <= r_we ? '0 : i_mem_rd;
         end
      end
   end

   always_comb begin
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_mem_a      = '0;
      o_mem_wd     = '0;
      o_mem_funct3 = 3'b000;
      o_rsp_valid  = 2'b00;
      o_rsp_rdata  = r_rsp_rdata;
      if (r_state == ISSUE) begin
         // Gated by reset so a reset landing mid-access cannot commit a write.
         o_mem_read   = ~r_we & ~i_reset;
         o_mem_write  = r_we & ~i_reset;
         o_mem_a      = r_addr;
         o_mem_wd     = r_wdata;
         o_mem_funct3 = r_funct3;
      end
      if (r_state == RESP) begin
         o_rsp_valid[r_owner] = 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed memory model and a
// separate reference memory that predicts every response.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW = 9;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0]      req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [5:0]      req_funct3;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            mem_read;
   logic            mem_write;
   logic [AW-1:0]   mem_a;
   logic [DW-1:0]   mem_wd;
   logic [2:0]      mem_funct3;
   logic [DW-1:0]   mem_rd;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [2:0]    f3;
   } req_t;

   typedef struct {
      int            port;
      logic [DW-1:0] rdata;
      int            cyc;
   } exp_t;

   req_t q0[$];
   req_t q1[$];
   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_cyc_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   wr_cycles = 0;
   int   wr0;

   logic [7:0] dmem    [512] = '{default: 8'h00};
   logic [7:0] ref_mem [512] = '{default: 8'h00};

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .i_req_funct3 (req_funct3),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_rdata  (rsp_rdata),
      .o_mem_read   (mem_read),
      .o_mem_write  (mem_write),
      .o_mem_a      (mem_a),
      .o_mem_wd     (mem_wd),
      .o_mem_funct3 (mem_funct3),
      .i_mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      case (f3)
         3'b000:  return 1;
         3'b001:  return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [7:0] gb(input bit use_ref, input logic [AW-1:0] a);
      return use_ref ? ref_mem[a] : dmem[a];
   endfunction

   function automatic logic [31:0] ld(input bit use_ref, input logic [AW-1:0] a,
                                      input logic [2:0] f3);
      logic [7:0] b0, b1, b2, b3;
      b0 = gb(use_ref, a);
      b1 = gb(use_ref, a + 9'd1);
      b2 = gb(use_ref, a + 9'd2);
      b3 = gb(use_ref, a + 9'd3);
      case (f3)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b100:  return {24'h0, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   task automatic ref_st(input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f3);
      for (int i = 0; i < nbytes(f3); i++) ref_mem[a + 9'(i)] = d[8*i +: 8];
   endtask

   // Memory under the DUT: combinational read, write on the rising edge.
   assign mem_rd = ld(1'b0, mem_a, mem_funct3);

   always @(posedge clk) begin
      if (mem_write) begin
         for (int i = 0; i < 4; i++) begin
            if (i < nbytes(mem_funct3)) dmem[mem_a + 9'(i)] <= mem_wd[8*i +: 8];
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (mem_write) wr_cycles++;
      if (mem_read || mem_write) check("ready_in_issue", 32'(req_ready), 32'd0);
      if (rsp_valid != 2'b00) begin
         check("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_port", 32'(rsp_valid), 32'(2'b01 << e.port));
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic drive(input int p, input req_t r);
      req_we[p]             = r.we;
      req_addr[p*AW +: AW]  = r.addr;
      req_wdata[p*DW +: DW] = r.wdata;
      req_funct3[p*3 +: 3]  = r.f3;
   endtask

   function automatic req_t mk(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [2:0] f3);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d; r.f3 = f3;
      return r;
   endfunction

   // Called at a falling edge; presents queued requests and books each accept.
   task automatic run_queues(input int max_cyc);
      int n = 0;
      req_t r;
      exp_t e;
      while ((q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
         req_valid = {q1.size() != 0, q0.size() != 0};
         if (q0.size() != 0) drive(0, q0[0]);
         if (q1.size() != 0) drive(1, q1[0]);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (req_valid[p] && req_ready[p]) begin
               if (p == 0) r = q0.pop_front();
               else        r = q1.pop_front();
               e.port = p;
               e.cyc  = cyc + 2;
               if (r.we) begin
                  e.rdata = '0;
                  ref_st(r.addr, r.wdata, r.f3);
               end else begin
                  e.rdata = ld(1'b1, r.addr, r.f3);
               end
               exp_q.push_back(e);
               acc_q.push_back(p);
               acc_cyc_q.push_back(cyc);
            end
         end
         @(negedge clk);
         n++;
      end
      req_valid = 2'b00;
      if (q0.size() != 0 || q1.size() != 0) check("accept_timeout", 32'd1, 32'd0);
      q0.delete();
      q1.delete();
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic check_reset_vals();
      check("rst_ready", 32'(req_ready), 32'd3);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_rw", 32'({mem_read, mem_write}), 32'd0);
      check("rst_mem_a", 32'(mem_a), 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
      check("rst_mem_f3", 32'(mem_funct3), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 2'b00;
      req_we     = 2'b00;
      req_addr   = '0;
      req_wdata  = '0;
      req_funct3 = '0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      @(negedge clk);

      // Port 0 store then load of the same word.
      wr0 = wr_cycles;
      q0.push_back(mk(1'b1, 9'h010, 32'hDEADBEEF, F3_W));
      run_queues(20);
      wait_drain(20);
      check("t1_store_write_cycles", 32'(wr_cycles - wr0), 32'd1);
      q0.push_back(mk(1'b0, 9'h010, 32'h0, F3_W));
      run_queues(20);
      wait_drain(20);

      // Both ports contend straight out of reset.
      q0.push_back(mk(1'b1, 9'h004, 32'h11112222, F3_W));
      run_queues(20);
      q1.push_back(mk(1'b1, 9'h008, 32'h33334444, F3_W));
      run_queues(20);
      wait_drain(20);
      do_reset();
      acc_q.delete();
      acc_cyc_q.delete();
      q0.push_back(mk(1'b0, 9'h004, 32'h0, F3_W));
      q1.push_back(mk(1'b0, 9'h008, 32'h0, F3_W));
      run_queues(20);
      wait_drain(20);
      check("t2_accepts", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() == 2) begin
         check("t2_first", 32'(acc_q[0]), 32'd0);
         check("t2_second", 32'(acc_q[1]), 32'd1);
         check("t2_gap", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd2);
      end

      // Continuous contention: grants alternate, starting from port 0.
      acc_q.delete();
      acc_cyc_q.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk(1'($urandom_range(0, 1)), 9'h100 + 9'(4 * $urandom_range(0, 15)),
                         $urandom, F3_W));
         q1.push_back(mk(1'($urandom_range(0, 1)), 9'h100 + 9'(4 * $urandom_range(0, 15)),
                         $urandom, F3_W));
      end
      run_queues(60);
      wait_drain(20);
      check("t4_accepts", 32'(acc_q.size()), 32'd8);
      for (int i = 0; i < acc_q.size(); i++) begin
         check("t4_alternate", 32'(acc_q[i]), 32'(i % 2));
         if (i > 0) check("t4_throughput", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd2);
      end

      // Byte store by port 1, then signed and unsigned byte loads by port 0.
      q1.push_back(mk(1'b1, 9'h020, 32'h000000FF, F3_B));
      run_queues(20);
      wait_drain(20);
      q0.push_back(mk(1'b0, 9'h020, 32'h0, F3_B));
      q0.push_back(mk(1'b0, 9'h020, 32'h0, F3_BU));
      run_queues(20);
      wait_drain(20);
      check("t3_ref_lb", ld(1'b0, 9'h020, F3_B), 32'hFFFFFFFF);
      check("t3_ref_lbu", ld(1'b0, 9'h020, F3_BU), 32'h000000FF);

      // Reset during the ISSUE cycle of a store drops it.
      q0.push_back(mk(1'b1, 9'h030, 32'hCAFEF00D, F3_W));
      run_queues(20);
      wait_drain(20);
      drive(0, mk(1'b1, 9'h030, 32'h12345678, F3_W));
      req_valid = 2'b01;
      #1;
      check("t5_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      check("t5_issue_write", 32'(mem_write), 32'd1);
      check("t5_issue_addr", 32'(mem_a), 32'h030);
      rst = 1'b1;
      #1;
      check("t5_write_gated", 32'({mem_read, mem_write}), 32'd0);
      @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      q0.push_back(mk(1'b0, 9'h030, 32'h0, F3_W));
      run_queues(20);
      wait_drain(20);

      // A request raised only during ISSUE is never accepted.
      wr0 = wr_cycles;
      q1.push_back(mk(1'b0, 9'h030, 32'h0, F3_W));
      run_queues(20);
      drive(0, mk(1'b1, 9'h040, 32'hA5A5A5A5, F3_W));
      req_valid = 2'b01;
      #1;
      check("t6_ready_issue", 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = 2'b00;
      wait_drain(20);
      repeat (3) @(negedge clk);
      check("t6_no_write", 32'(wr_cycles - wr0), 32'd0);
      q1.push_back(mk(1'b0, 9'h040, 32'h0, F3_W));
      run_queues(20);
      wait_drain(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
